// File: rtl/alu_mux_sequencer.sv
// -----------------------------------------------------------------------------
// alu_mux_sequencer
//
// Upstream control/capture stage for the 16-bit 4:1 ALU result mux.
// One operation (select code plus four operands) is accepted, then driven
// onto the mux operand buses and selects. Those drives are held stable for
// SETTLE cycles so the adiabatic mux chain can settle. The mux output is then
// captured into a result register and returned through a second handshake.
//
// Handshakes (both sides): a transfer happens on a rising clkpos edge where
// valid && ready are both high. A producer holds valid and its payload until
// that edge. in_valid seen while in_ready is low is ignored, not queued.
// res_valid stays high, and res_data stays stable, until res_ready is seen.
//
// Parameters:
//   WIDTH   operand/result width; must match the mux bus width
//   SETTLE  cycles the mux inputs are held before capture (>= 1)
//
// Ports:
//   clkpos              single clock, rising edge
//   rst                 synchronous, active-high reset
//   in_valid/in_ready   operation handshake (in_ready high only in IDLE)
//   in_sel              operand select: 0->a, 1->b, 2->c, 3->d
//   in_a..in_d          operands, sampled on accept
//   mux_a..mux_d        registered operand drives to the mux
//   mux_in0/mux_in1     registered select LSB/MSB
//   mux_out             mux result, sampled at capture
//   res_valid/res_ready result handshake
//   res_data            captured result
//   busy                high while an operation is in HOLD or DONE
//   res_zero            (only with ALU_MUX_SEQ_ZFLAG_EN) captured result == 0
//   dbg_state           current FSM state, for observation
//
// Optional feature macro: ALU_MUX_SEQ_ZFLAG_EN adds the res_zero output.
// -----------------------------------------------------------------------------
module alu_mux_sequencer #(
    parameter int WIDTH  = 16,
    parameter int SETTLE = 4
) (
    input  logic             clkpos,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_sel,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_c,
    input  logic [WIDTH-1:0] in_d,
    output logic [WIDTH-1:0] mux_a,
    output logic [WIDTH-1:0] mux_b,
    output logic [WIDTH-1:0] mux_c,
    output logic [WIDTH-1:0] mux_d,
    output logic             mux_in0,
    output logic             mux_in1,
    input  logic [WIDTH-1:0] mux_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             busy,
`ifdef ALU_MUX_SEQ_ZFLAG_EN
    output logic             res_zero,
`endif
    output logic [1:0]       dbg_state
);

    localparam int CNT_W = $clog2(SETTLE + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic               accept;
    logic               capture;
    logic               release_res;

    assign accept      = in_valid && (state == IDLE);
    assign capture     = (state == HOLD) && (cnt == '0);
    assign release_res = (state == DONE) && res_ready;

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign dbg_state = state;

    // State register.
    always_ff @(posedge clkpos) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)     state_nxt = HOLD;
            HOLD:    if (cnt == '0)    state_nxt = DONE;
            DONE:    if (res_ready)    state_nxt = IDLE;
            default:                   state_nxt = IDLE;
        endcase
    end

    // Datapath. The mux drives are only ever loaded on accept, so they keep
    // their last values through DONE and IDLE and the mux chain sees no
    // transitions between operations.
    always_ff @(posedge clkpos) begin
        if (rst) begin
            mux_a     <= '0;
            mux_b     <= '0;
            mux_c     <= '0;
            mux_d     <= '0;
            mux_in0   <= 1'b0;
            mux_in1   <= 1'b0;
            cnt       <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
        end else begin
            if (accept) begin
                mux_a   <= in_a;
                mux_b   <= in_b;
                mux_c   <= in_c;
                mux_d   <= in_d;
                mux_in0 <= in_sel[0];
                mux_in1 <= in_sel[1];
                // Counting SETTLE-1 down to 0 puts the capture edge exactly
                // SETTLE edges after the accept edge.
                cnt     <= CNT_W'(SETTLE - 1);
            end else if ((state == HOLD) && (cnt != '0)) begin
                cnt <= cnt - CNT_W'(1);
            end

            if (capture) begin
                res_data  <= mux_out;
                res_valid <= 1'b1;
            end else if (release_res) begin
                res_valid <= 1'b0;
            end
        end
    end

`ifdef ALU_MUX_SEQ_ZFLAG_EN
    // Zero flag travels with res_data: same load edge, same hold.
    always_ff @(posedge clkpos) begin
        if (rst) begin
            res_zero <= 1'b0;
        end else if (capture) begin
            res_zero <= (mux_out == '0);
        end
    end
`endif

endmodule

// File: tb/tb_alu_mux_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_mux_sequencer
//
// Two instances: k=0 with SETTLE=4, k=1 with SETTLE=1. Each drives a simple
// 4:1 mux model fed from its own mux_* outputs. A transaction-level model
// (accept timestamps, expected-result queue) predicts every output on every
// falling edge; driver tasks add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_alu_mux_sequencer;

    localparam int W = 16;

    // ---------------- clock / reset ----------------
    logic clkpos = 1'b0;
    always #5 clkpos = ~clkpos;

    logic rst;
    int   cyc = 0;
    always @(posedge clkpos) cyc <= cyc + 1;

    // ---------------- DUT signals (index = instance) ----------------
    logic         in_valid  [2];
    logic         in_ready  [2];
    logic         res_ready [2];
    logic         res_valid [2];
    logic         busy      [2];
    logic         mux_in0   [2];
    logic         mux_in1   [2];
    logic [1:0]   in_sel    [2];
    logic [1:0]   dbg_state [2];
    logic [W-1:0] in_a [2], in_b [2], in_c [2], in_d [2];
    logic [W-1:0] mux_a [2], mux_b [2], mux_c [2], mux_d [2];
    logic [W-1:0] mux_out [2], res_data [2];
`ifdef ALU_MUX_SEQ_ZFLAG_EN
    logic         res_zero  [2];
`endif

    alu_mux_sequencer #(.WIDTH(W), .SETTLE(4)) dut4 (
        .clkpos(clkpos), .rst(rst),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_sel(in_sel[0]),
        .in_a(in_a[0]), .in_b(in_b[0]), .in_c(in_c[0]), .in_d(in_d[0]),
        .mux_a(mux_a[0]), .mux_b(mux_b[0]), .mux_c(mux_c[0]), .mux_d(mux_d[0]),
        .mux_in0(mux_in0[0]), .mux_in1(mux_in1[0]), .mux_out(mux_out[0]),
        .res_valid(res_valid[0]), .res_ready(res_ready[0]), .res_data(res_data[0]),
        .busy(busy[0]),
`ifdef ALU_MUX_SEQ_ZFLAG_EN
        .res_zero(res_zero[0]),
`endif
        .dbg_state(dbg_state[0])
    );

    alu_mux_sequencer #(.WIDTH(W), .SETTLE(1)) dut1 (
        .clkpos(clkpos), .rst(rst),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_sel(in_sel[1]),
        .in_a(in_a[1]), .in_b(in_b[1]), .in_c(in_c[1]), .in_d(in_d[1]),
        .mux_a(mux_a[1]), .mux_b(mux_b[1]), .mux_c(mux_c[1]), .mux_d(mux_d[1]),
        .mux_in0(mux_in0[1]), .mux_in1(mux_in1[1]), .mux_out(mux_out[1]),
        .res_valid(res_valid[1]), .res_ready(res_ready[1]), .res_data(res_data[1]),
        .busy(busy[1]),
`ifdef ALU_MUX_SEQ_ZFLAG_EN
        .res_zero(res_zero[1]),
`endif
        .dbg_state(dbg_state[1])
    );

    // ---------------- environment: the 4:1 mux ----------------
    function automatic logic [W-1:0] pick(input logic s1, input logic s0,
                                          input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [W-1:0] c, input logic [W-1:0] d);
        case ({s1, s0})
            2'd0:    return a;
            2'd1:    return b;
            2'd2:    return c;
            default: return d;
        endcase
    endfunction

    assign mux_out[0] = pick(mux_in1[0], mux_in0[0], mux_a[0], mux_b[0], mux_c[0], mux_d[0]);
    assign mux_out[1] = pick(mux_in1[1], mux_in0[1], mux_a[1], mux_b[1], mux_c[1], mux_d[1]);

    // ---------------- scoreboard bookkeeping ----------------
    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] got=%h want=%h (cycle %0d)", nm, k, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Per instance: is an operation outstanding, at which edge was it accepted,
    // what the mux drives and select should be, and the last captured result.
    bit           m_on   [2];
    bit           m_busy [2];
    int           m_acc  [2];
    logic [W-1:0] m_mux  [2][4];
    logic [1:0]   m_sel  [2];
    logic [W-1:0] m_res  [2];
    logic [W-1:0] exp_q0[$];
    logic [W-1:0] exp_q1[$];
    int           acc_q1[$];

    function automatic int settle_of(input int k);
        return (k == 0) ? 4 : 1;
    endfunction

    task automatic model_step(input int k);
        int s;
        bit exp_rv;
        logic [W-1:0] ops [4];
        s = settle_of(k);
        exp_rv = m_busy[k] && (cyc >= m_acc[k] + s);

        // The result appears exactly SETTLE edges after the accept edge.
        if (m_busy[k] && (cyc == m_acc[k] + s)) begin
            if (k == 0 && exp_q0.size() > 0) m_res[k] = exp_q0.pop_front();
            if (k == 1 && exp_q1.size() > 0) m_res[k] = exp_q1.pop_front();
        end

        if (m_on[k]) begin
            chk("in_ready",  k, in_ready[k],  !m_busy[k]);
            chk("busy",      k, busy[k],      m_busy[k]);
            chk("res_valid", k, res_valid[k], exp_rv);
            chk("res_data",  k, res_data[k],  m_res[k]);
            chk("mux_a",     k, mux_a[k],     m_mux[k][0]);
            chk("mux_b",     k, mux_b[k],     m_mux[k][1]);
            chk("mux_c",     k, mux_c[k],     m_mux[k][2]);
            chk("mux_d",     k, mux_d[k],     m_mux[k][3]);
            chk("mux_in0",   k, mux_in0[k],   m_sel[k][0]);
            chk("mux_in1",   k, mux_in1[k],   m_sel[k][1]);
`ifdef ALU_MUX_SEQ_ZFLAG_EN
            chk("res_zero",  k, res_zero[k],  (m_res[k] == '0));
`endif
        end

        // Predict the effect of the coming rising edge from the current inputs.
        if (rst) begin
            m_on[k]   = 1'b1;
            m_busy[k] = 1'b0;
            m_sel[k]  = 2'd0;
            m_res[k]  = '0;
            for (int i = 0; i < 4; i++) m_mux[k][i] = '0;
            if (k == 0) exp_q0.delete(); else exp_q1.delete();
        end else if (m_on[k] && !m_busy[k] && in_valid[k]) begin
            ops[0] = in_a[k]; ops[1] = in_b[k]; ops[2] = in_c[k]; ops[3] = in_d[k];
            m_busy[k] = 1'b1;
            m_acc[k]  = cyc + 1;
            m_sel[k]  = in_sel[k];
            for (int i = 0; i < 4; i++) m_mux[k][i] = ops[i];
            if (k == 0) exp_q0.push_back(ops[in_sel[k]]);
            else begin
                exp_q1.push_back(ops[in_sel[k]]);
                acc_q1.push_back(cyc + 1);
            end
        end else if (exp_rv && res_ready[k]) begin
            m_busy[k] = 1'b0;
        end
    endtask

    always @(negedge clkpos) begin
        for (int k = 0; k < 2; k++) model_step(k);
    end

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(posedge clkpos);
        #1;
    endtask

    task automatic scramble(input int k);
        in_a[k]   = W'($urandom);
        in_b[k]   = W'($urandom);
        in_c[k]   = W'($urandom);
        in_d[k]   = W'($urandom);
        in_sel[k] = 2'($urandom_range(0, 3));
    endtask

    // One operation with res_ready already high. Operands are scrambled every
    // cycle while the operation is in flight. Checks latency and result.
    task automatic do_op(input int k, input logic [1:0] sel,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] c, input logic [W-1:0] d,
                         input logic [W-1:0] want, input int want_lat);
        int n;
        in_sel[k] = sel; in_a[k] = a; in_b[k] = b; in_c[k] = c; in_d[k] = d;
        in_valid[k] = 1'b1;
        next_cycle();
        in_valid[k] = 1'b0;
        n = 0;
        while (res_valid[k] !== 1'b1 && n < 20) begin
            scramble(k);
            next_cycle();
            n++;
        end
        chk("latency",  k, n, want_lat);
        chk("res_lit",  k, res_data[k], want);
        next_cycle();
    endtask

    // ---------------- stimulus ----------------
    logic [W-1:0] lit_tab [4];
    logic [W-1:0] held_data;
    logic [W-1:0] held_mux;
    int           n_res;
    int           n_wait;

    initial begin
        lit_tab[0] = 16'h1111; lit_tab[1] = 16'h2222;
        lit_tab[2] = 16'h3333; lit_tab[3] = 16'h4444;
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            in_valid[k] = 1'b0; res_ready[k] = 1'b1; in_sel[k] = 2'd0;
            in_a[k] = '0; in_b[k] = '0; in_c[k] = '0; in_d[k] = '0;
        end
        repeat (3) @(posedge clkpos);
        #1;
        rst = 1'b0;

        // Reset state.
        for (int k = 0; k < 2; k++) begin
            chk("rst_in_ready",  k, in_ready[k],  1'b1);
            chk("rst_res_valid", k, res_valid[k], 1'b0);
            chk("rst_res_data",  k, res_data[k],  16'h0000);
            chk("rst_mux_a",     k, mux_a[k],     16'h0000);
            chk("rst_busy",      k, busy[k],      1'b0);
        end

        // Select map, SETTLE=4.
        for (int s = 0; s < 4; s++)
            do_op(0, 2'(s), 16'h1111, 16'h2222, 16'h3333, 16'h4444, lit_tab[s], 4);

        // Reset in the middle of HOLD abandons the operation.
        in_sel[0] = 2'd3; in_d[0] = 16'hDEAD; in_valid[0] = 1'b1;
        next_cycle();
        in_valid[0] = 1'b0;
        next_cycle();
        rst = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b0;
        chk("midrst_in_ready",  0, in_ready[0],  1'b1);
        chk("midrst_res_valid", 0, res_valid[0], 1'b0);
        chk("midrst_mux_d",     0, mux_d[0],     16'h0000);
        chk("midrst_mux_in",    0, {mux_in1[0], mux_in0[0]}, 2'd0);
        n_res = 0;
        repeat (8) begin
            next_cycle();
            if (res_valid[0] === 1'b1) n_res++;
        end
        chk("midrst_no_result", 0, n_res, 0);

        // Stall: result held, extra requests ignored, release returns to IDLE.
        res_ready[0] = 1'b0;
        in_sel[0] = 2'd2; in_a[0] = 16'h0A0A; in_b[0] = 16'h0B0B;
        in_c[0] = 16'hBEEF; in_d[0] = 16'h0D0D; in_valid[0] = 1'b1;
        next_cycle();
        in_valid[0] = 1'b0;
        n_wait = 0;
        while (res_valid[0] !== 1'b1 && n_wait < 20) begin
            scramble(0);
            next_cycle();
            n_wait++;
        end
        chk("stall_latency", 0, n_wait, 4);
        chk("stall_res_lit", 0, res_data[0], 16'hBEEF);
        held_data = res_data[0];
        held_mux  = mux_c[0];
        repeat (10) begin
            scramble(0);
            in_valid[0] = 1'($urandom_range(0, 1));
            next_cycle();
            chk("stall_res_data", 0, res_data[0], held_data);
            chk("stall_mux_c",    0, mux_c[0],    held_mux);
            chk("stall_in_ready", 0, in_ready[0], 1'b0);
        end
        in_valid[0]  = 1'b0;
        res_ready[0] = 1'b1;
        next_cycle();
        chk("release_in_ready",  0, in_ready[0],  1'b1);
        chk("release_res_valid", 0, res_valid[0], 1'b0);

`ifdef ALU_MUX_SEQ_ZFLAG_EN
        do_op(0, 2'd0, 16'h0000, 16'h1234, 16'h5678, 16'h8000, 16'h0000, 4);
        chk("zflag_zero", 0, res_zero[0], 1'b1);
        do_op(0, 2'd3, 16'h0000, 16'h1234, 16'h5678, 16'h8000, 16'h8000, 4);
        chk("zflag_nonzero", 0, res_zero[0], 1'b0);
`endif

        // Randomized traffic on the SETTLE=4 instance.
        repeat (400) begin
            scramble(0);
            if ($urandom_range(0, 3) == 0) in_a[0] = '0;
            in_valid[0]  = 1'($urandom_range(0, 1));
            res_ready[0] = ($urandom_range(0, 3) != 0);
            next_cycle();
        end
        in_valid[0]  = 1'b0;
        res_ready[0] = 1'b1;
        repeat (8) next_cycle();

        // SETTLE=1 boundary: single operations, then back-to-back requests.
        do_op(1, 2'd1, 16'h00F0, 16'h0F00, 16'hF000, 16'h000F, 16'h0F00, 1);
        do_op(1, 2'd3, 16'h00F0, 16'h0F00, 16'hF000, 16'h000F, 16'h000F, 1);
        acc_q1.delete();
        res_ready[1] = 1'b1;
        in_valid[1]  = 1'b1;
        repeat (15) begin
            scramble(1);
            next_cycle();
        end
        in_valid[1] = 1'b0;
        repeat (4) next_cycle();
        chk("b2b_accepts", 1, acc_q1.size(), 5);
        for (int i = 1; i < acc_q1.size(); i++)
            chk("b2b_gap", 1, acc_q1[i] - acc_q1[i-1], 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
